// File: rtl/control_mem_vectorial_pkg.sv
// Shared constants and state encoding for the vector memory access controller.
package control_mem_vectorial_pkg;

  localparam int LANES  = 4;
  localparam int LANE_W = 8;
  localparam int ADDR_W = 8;
  localparam int DATA_W = LANES * LANE_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/control_mem_vectorial_if.sv
// Pipeline request/response and byte-wide data memory signals of the controller.
// The controller uses the slave view; the pipeline/memory side uses the master view.
interface control_mem_vectorial_if
  import control_mem_vectorial_pkg::*;
#(
  parameter int ADDR_W = 8
);

  logic              req_valid;
  logic              req_vec;
  logic              req_wr;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic              stall;

  logic [ADDR_W-1:0] mem_addr;
  logic [LANE_W-1:0] mem_wdata;
  logic              mem_we;
  logic [LANE_W-1:0] mem_rdata;

  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;

  modport slave (
    input  req_valid, req_vec, req_wr, req_addr, req_data, mem_rdata,
    output stall, mem_addr, mem_wdata, mem_we, rd_data, rd_valid
  );

  modport master (
    output req_valid, req_vec, req_wr, req_addr, req_data, mem_rdata,
    input  stall, mem_addr, mem_wdata, mem_we, rd_data, rd_valid
  );

endinterface

// File: rtl/control_mem_vectorial.sv
// Serialises scalar or 4-lane vector loads/stores onto a byte-wide data memory,
// stalling the pipeline until the access completes. Only LANES = 4 is supported.
module control_mem_vectorial #(
  parameter int LANES  = 4,
  parameter int ADDR_W = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  control_mem_vectorial_if.slave  bus
);
  import control_mem_vectorial_pkg::*;

  localparam int LW = $clog2(LANES);
  localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);
  localparam int BUF_W = (LANES - 1) * LANE_W;

  state_t            state_q;
  logic              vec_q;
  logic              wr_q;
  logic [ADDR_W-1:0] base_q;
  logic [DATA_W-1:0] data_q;
  logic [LW-1:0]     lane_q;
  logic [BUF_W-1:0]  load_buf_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q;
  logic              last_lane;

  // Lane 0 is the only lane of a scalar access; vectors end on lane LANES-1.
  assign last_lane = (lane_q == (vec_q ? LAST_LANE : '0));

  // Request sequencing: latch, issue one lane per cycle, drain the last read, complete.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      vec_q      <= 1'b0;
      wr_q       <= 1'b0;
      base_q     <= '0;
      data_q     <= '0;
      lane_q     <= '0;
      load_buf_q <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            vec_q   <= bus.req_vec;
            wr_q    <= bus.req_wr;
            base_q  <= bus.req_addr;
            data_q  <= bus.req_data;
            lane_q  <= '0;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          // Read data trails its address by one cycle, so this cycle returns lane-1.
          if (!wr_q && lane_q != '0) begin
            load_buf_q[LANE_W*(int'(lane_q)-1) +: LANE_W] <= bus.mem_rdata;
          end
          if (last_lane) begin
            state_q <= wr_q ? DONE : DRAIN;
          end else begin
            lane_q <= lane_q + 1'b1;
          end
        end
        DRAIN: begin
          rd_data_q  <= vec_q ? {bus.mem_rdata, load_buf_q}
                              : {{(DATA_W-LANE_W){1'b0}}, bus.mem_rdata};
          rd_valid_q <= 1'b1;
          state_q    <= DONE;
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // lane_q parks on the last issued lane, so address/data hold outside ISSUE.
  assign bus.stall     = (state_q == IDLE && bus.req_valid) ||
                         (state_q == ISSUE) || (state_q == DRAIN);
  assign bus.mem_we    = (state_q == ISSUE) && wr_q;
  assign bus.mem_addr  = base_q + ADDR_W'(lane_q);
  assign bus.mem_wdata = data_q[LANE_W*lane_q +: LANE_W];
  assign bus.rd_data   = rd_data_q;
  assign bus.rd_valid  = rd_valid_q;

endmodule

// File: tb/tb_control_mem_vectorial.sv
// Self-checking bench: byte memory model, scoreboard of expected writes/loads,
// one task per scenario.
module tb_control_mem_vectorial;
  import control_mem_vectorial_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  logic [15:0] wr_exp[$];
  logic [31:0] rd_exp[$];

  logic       pre_we;
  logic [7:0] pre_addr;
  logic [7:0] pre_data;
  logic [7:0] mem [0:255];

  control_mem_vectorial_if #(.ADDR_W(8)) bus();

  control_mem_vectorial #(.LANES(4), .ADDR_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Synchronous byte memory: read data appears the cycle after its address.
  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= mem[bus.mem_addr];
  end

  // Scoreboard: every write pulse and load strobe must match the next expectation.
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      checks++;
      if (wr_exp.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_write got addr=%h data=%h, expected none", bus.mem_addr, bus.mem_wdata);
      end else begin
        logic [15:0] w;
        w = wr_exp.pop_front();
        if ({bus.mem_addr, bus.mem_wdata} !== w) begin
          errors++;
          $display("[TB] FAIL write got addr=%h data=%h, expected addr=%h data=%h", bus.mem_addr, bus.mem_wdata, w[15:8], w[7:0]);
        end
      end
    end
    if (bus.rd_valid === 1'b1) begin
      checks++;
      if (rd_exp.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_rd_valid got rd_data=%h, expected no strobe", bus.rd_data);
      end else begin
        logic [31:0] r;
        r = rd_exp.pop_front();
        if (bus.rd_data !== r) begin
          errors++;
          $display("[TB] FAIL load_data got %h, expected %h", bus.rd_data, r);
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired, simulation did not complete");
    $fatal(1, "[TB] watchdog");
  end

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    pre_addr = a;
    pre_data = d;
    pre_we   = 1'b1;
    @(posedge clk);
    #1 pre_we = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Presents one request now, pushes expectations, counts stall cycles up to DONE.
  task automatic run_op(input logic vec, input logic wr, input logic [7:0] addr,
                        input logic [31:0] data, input logic [31:0] exp_rd,
                        input int exp_stall, input bit scramble, input string name);
    int n;
    bus.req_valid = 1'b1;
    bus.req_vec   = vec;
    bus.req_wr    = wr;
    bus.req_addr  = addr;
    bus.req_data  = data;
    if (wr) begin
      for (int i = 0; i < (vec ? 4 : 1); i++)
        wr_exp.push_back({addr + 8'(i), data[8*i +: 8]});
    end else begin
      rd_exp.push_back(exp_rd);
    end
    n = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.stall !== 1'b1) break;
      n++;
      if (scramble && n >= 2) begin
        bus.req_vec  = 1'($urandom);
        bus.req_wr   = 1'($urandom);
        bus.req_addr = 8'($urandom);
        bus.req_data = $urandom;
      end
    end
    checks++;
    if (n != exp_stall) begin
      errors++;
      $display("[TB] FAIL %s_stall_cycles got %0d, expected %0d", name, n, exp_stall);
    end
    checks++;
    if (bus.rd_valid !== !wr) begin
      errors++;
      $display("[TB] FAIL %s_rd_valid_in_done got %b, expected %b", name, bus.rd_valid, !wr);
    end
  endtask

  task automatic test_reset();
    reset         = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_vec   = 1'b0;
    bus.req_wr    = 1'b0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    pre_we        = 1'b0;
    pre_addr      = '0;
    pre_data      = '0;
    @(posedge clk);
    #1;
    preload(8'h20, 8'h11);
    preload(8'h21, 8'h22);
    preload(8'h22, 8'h33);
    preload(8'h23, 8'h44);
    preload(8'h05, 8'h9C);
    for (int i = 0; i < 4; i++) preload(8'h40 + 8'(i), 8'hA0 + 8'(i));
    @(negedge clk);
    checks += 6;
    if (bus.stall !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall got %b, expected 0", bus.stall); end
    if (bus.mem_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_we got %b, expected 0", bus.mem_we); end
    if (bus.rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rd_valid got %b, expected 0", bus.rd_valid); end
    if (bus.rd_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_rd_data got %h, expected 0", bus.rd_data); end
    if (bus.mem_addr !== 8'h0) begin errors++; $display("[TB] FAIL reset_mem_addr got %h, expected 0", bus.mem_addr); end
    if (bus.mem_wdata !== 8'h0) begin errors++; $display("[TB] FAIL reset_mem_wdata got %h, expected 0", bus.mem_wdata); end
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Issued in the very first cycle out of reset.
  task automatic test_vector_store();
    run_op(1'b1, 1'b1, 8'h10, 32'hDDCCBBAA, 32'h0, 5, 1'b0, "vec_store");
    idle_cycles(2);
    checks += 4;
    if (bus.mem_we !== 1'b0) begin errors++; $display("[TB] FAIL idle_mem_we got %b, expected 0", bus.mem_we); end
    if (bus.mem_addr !== 8'h13) begin errors++; $display("[TB] FAIL hold_mem_addr got %h, expected 13", bus.mem_addr); end
    if (bus.mem_wdata !== 8'hDD) begin errors++; $display("[TB] FAIL hold_mem_wdata got %h, expected dd", bus.mem_wdata); end
    if (wr_exp.size() != 0) begin errors++; $display("[TB] FAIL vec_store_writes_left got %0d, expected 0", wr_exp.size()); end
  endtask

  task automatic test_vector_load();
    run_op(1'b1, 1'b0, 8'h20, 32'h0, 32'h44332211, 6, 1'b0, "vec_load");
    idle_cycles(2);
    checks += 2;
    if (bus.rd_data !== 32'h44332211) begin errors++; $display("[TB] FAIL vec_load_hold got %h, expected 44332211", bus.rd_data); end
    if (rd_exp.size() != 0) begin errors++; $display("[TB] FAIL vec_load_pending got %0d, expected 0", rd_exp.size()); end
  endtask

  task automatic test_scalar();
    run_op(1'b0, 1'b0, 8'h05, 32'h0, 32'h0000009C, 3, 1'b0, "scalar_load");
    idle_cycles(1);
    run_op(1'b0, 1'b1, 8'h30, 32'h12345678, 32'h0, 2, 1'b0, "scalar_store");
    idle_cycles(2);
    checks += 3;
    if (bus.rd_data !== 32'h0000009C) begin errors++; $display("[TB] FAIL rd_data_hold_after_store got %h, expected 0000009c", bus.rd_data); end
    if (bus.mem_addr !== 8'h30) begin errors++; $display("[TB] FAIL scalar_store_addr_hold got %h, expected 30", bus.mem_addr); end
    if (wr_exp.size() != 0) begin errors++; $display("[TB] FAIL scalar_store_writes_left got %0d, expected 0", wr_exp.size()); end
  endtask

  task automatic test_wrap();
    run_op(1'b1, 1'b1, 8'hFE, 32'h04030201, 32'h0, 5, 1'b0, "wrap_store");
    idle_cycles(1);
    run_op(1'b1, 1'b0, 8'hFE, 32'h0, 32'h04030201, 6, 1'b0, "wrap_load");
    idle_cycles(1);
  endtask

  // Inputs are randomised while the access is in flight, including the DONE cycle.
  task automatic test_input_hold();
    run_op(1'b1, 1'b1, 8'h50, 32'h87654321, 32'h0, 5, 1'b1, "hold_store");
    idle_cycles(1);
    run_op(1'b1, 1'b0, 8'h50, 32'h0, 32'h87654321, 6, 1'b1, "hold_load");
    idle_cycles(2);
    checks++;
    if (wr_exp.size() != 0 || rd_exp.size() != 0) begin
      errors++;
      $display("[TB] FAIL hold_pending got wr=%0d rd=%0d, expected 0 0", wr_exp.size(), rd_exp.size());
    end
  endtask

  // Next request is presented during each DONE cycle with req_valid held high.
  task automatic test_back_to_back();
    run_op(1'b1, 1'b1, 8'h60, 32'hA1B2C3D4, 32'h0, 5, 1'b0, "b2b_store");
    run_op(1'b1, 1'b0, 8'h60, 32'h0, 32'hA1B2C3D4, 6, 1'b0, "b2b_load");
    run_op(1'b0, 1'b0, 8'h05, 32'h0, 32'h0000009C, 3, 1'b0, "b2b_scalar");
    idle_cycles(3);
    checks += 2;
    if (bus.stall !== 1'b0) begin errors++; $display("[TB] FAIL b2b_idle_stall got %b, expected 0", bus.stall); end
    if (wr_exp.size() != 0 || rd_exp.size() != 0) begin
      errors++;
      $display("[TB] FAIL b2b_pending got wr=%0d rd=%0d, expected 0 0", wr_exp.size(), rd_exp.size());
    end
  endtask

  // Reset is sampled at the edge that would begin the second ISSUE cycle.
  task automatic test_reset_abort();
    bus.req_valid = 1'b1;
    bus.req_vec   = 1'b1;
    bus.req_wr    = 1'b1;
    bus.req_addr  = 8'h40;
    bus.req_data  = 32'h55443322;
    wr_exp.push_back({8'h40, 8'h22});
    @(negedge clk);
    checks++;
    if (bus.stall !== 1'b1) begin errors++; $display("[TB] FAIL abort_accept_stall got %b, expected 1", bus.stall); end
    @(posedge clk);
    #1;
    reset         = 1'b1;
    bus.req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks += 4;
    if (bus.stall !== 1'b0) begin errors++; $display("[TB] FAIL abort_stall got %b, expected 0", bus.stall); end
    if (bus.rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL abort_rd_valid got %b, expected 0", bus.rd_valid); end
    if (bus.mem_we !== 1'b0) begin errors++; $display("[TB] FAIL abort_mem_we got %b, expected 0", bus.mem_we); end
    if (bus.rd_data !== 32'h0) begin errors++; $display("[TB] FAIL abort_rd_data got %h, expected 0", bus.rd_data); end
    @(posedge clk);
    #1 reset = 1'b0;
    idle_cycles(2);
    checks++;
    if (wr_exp.size() != 0) begin errors++; $display("[TB] FAIL abort_lane0_write_missing got %0d pending, expected 0", wr_exp.size()); end
    run_op(1'b1, 1'b0, 8'h40, 32'h0, 32'hA3A2A122, 6, 1'b0, "abort_readback");
    idle_cycles(2);
    checks++;
    if (rd_exp.size() != 0) begin errors++; $display("[TB] FAIL abort_readback_pending got %0d, expected 0", rd_exp.size()); end
  endtask

  // Scenario sequence.
  initial begin
    test_reset();
    test_vector_store();
    test_vector_load();
    test_scalar();
    test_wrap();
    test_input_hold();
    test_back_to_back();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
